// File: rtl/jedro_1_sign_ext_if.sv
// jedro_1 sign extender bus: field in, extended value out.
// master drives the field and controls, slave returns results.
interface jedro_1_sign_ext_if #(
  parameter int N = 32,
  parameter int M = 12
);
  logic [M-1:0] in_i;
  logic         zext_i;
  logic         valid_i;
  logic         hold_i;
  logic [N-1:0] out_comb_o;
  logic [N-1:0] out_o;
  logic         valid_o;

  modport master (
    output in_i,
    output zext_i,
    output valid_i,
    output hold_i,
    input  out_comb_o,
    input  out_o,
    input  valid_o
  );

  modport slave (
    input  in_i,
    input  zext_i,
    input  valid_i,
    input  hold_i,
    output out_comb_o,
    output out_o,
    output valid_o
  );
endinterface

// File: rtl/jedro_1_sign_ext.sv
// jedro_1 immediate sign/zero extender, M -> N bits.
// Drives a same-cycle value and a one-stage registered copy.
module jedro_1_sign_ext #(
  parameter int N = 32,
  parameter int M = 12
) (
  input logic                clk_i,
  input logic                rst_i,
  jedro_1_sign_ext_if.slave  bus
);

  if (N < M) begin : g_bad_width
    $error("jedro_1_sign_ext: N must be >= M");
  end
  if (M < 1) begin : g_bad_field
    $error("jedro_1_sign_ext: M must be >= 1");
  end

  logic [N-1:0] ext;
  logic [N-1:0] out_q;
  logic         valid_q;

  if (N == M) begin : g_same
    assign ext = bus.in_i;
  end else begin : g_wide
    logic fill;
    assign fill = bus.zext_i ? 1'b0 : bus.in_i[M-1];
    assign ext  = {{(N-M){fill}}, bus.in_i};
  end

  // hold drops the incoming beat rather than queueing it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (bus.hold_i) begin
      out_q   <= out_q;
      valid_q <= valid_q;
    end else if (bus.valid_i) begin
      out_q   <= ext;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_comb_o = ext;
  assign bus.out_o      = out_q;
  assign bus.valid_o    = valid_q;

endmodule

// File: tb/tb_jedro_1_sign_ext.sv
// Scoreboard bench for jedro_1_sign_ext plus width sweeps.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_jedro_1_sign_ext;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jedro_1_sign_ext_if #(.N(32), .M(12)) bi ();
  jedro_1_sign_ext_if #(.N(8),  .M(8))  b8 ();
  jedro_1_sign_ext_if #(.N(16), .M(1))  b16 ();

  jedro_1_sign_ext #(.N(32), .M(12)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bi.slave));
  jedro_1_sign_ext #(.N(8), .M(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .bus(b8.slave));
  jedro_1_sign_ext #(.N(16), .M(1)) dut16 (
    .clk_i(clk), .rst_i(rst), .bus(b16.slave));

  typedef struct {
    logic [31:0] comb;
    logic [31:0] out;
    logic        val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  logic [31:0] m_out = '0;
  logic        m_val = 1'b0;

  // value of the field as a signed or unsigned number, modulo 2^n
  function automatic longint unsigned ext_m(
    longint unsigned v, int m, int n, bit z);
    longint unsigned r;
    longint unsigned mask;
    r = v;
    if (!z && v >= (64'd1 << (m-1)))
      r = v + (64'd1 << n) - (64'd1 << m);
    mask = (64'd1 << n) - 1;
    return r & mask;
  endfunction

  task automatic chk(string name, longint unsigned act,
                     longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  task automatic step(bit r, bit v, bit h, logic [11:0] d, bit z);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    bi.valid_i = v;
    bi.hold_i  = h;
    bi.in_i    = d;
    bi.zext_i  = z;
    e.comb = 32'(ext_m(64'(d), 12, 32, z));
    if (r) begin
      m_out = '0;
      m_val = 1'b0;
    end else if (!h) begin
      if (v) begin
        m_out = e.comb;
        m_val = 1'b1;
      end else begin
        m_val = 1'b0;
      end
    end
    e.out = m_out;
    e.val = m_val;
    q.push_back(e);
  endtask

  // registered checks lag the input item by one edge
  initial begin : monitor
    exp_t prev;
    exp_t cur;
    bit   have = 1'b0;
    forever begin
      @(negedge clk);
      if (have) begin
        chk("out_o", 64'(bi.out_o), 64'(prev.out));
        chk("valid_o", 64'(bi.valid_o), 64'(prev.val));
        have = 1'b0;
      end
      if (q.size() > 0) begin
        cur = q.pop_front();
        chk("out_comb_o", 64'(bi.out_comb_o), 64'(cur.comb));
        prev = cur;
        have = 1'b1;
      end
    end
  end

  initial begin : stim
    bi.in_i = '0; bi.zext_i = 0; bi.valid_i = 0; bi.hold_i = 0;
    b8.in_i = '0; b8.zext_i = 0; b8.valid_i = 0; b8.hold_i = 0;
    b16.in_i = '0; b16.zext_i = 0; b16.valid_i = 0; b16.hold_i = 0;
    step(1, 0, 0, 12'h000, 0);
    step(1, 1, 1, 12'h555, 0);
    step(0, 1, 0, 12'h7FF, 0);
    step(0, 1, 0, 12'h800, 0);
    step(0, 1, 0, 12'h800, 1);
    step(0, 1, 0, 12'hFFF, 0);
    step(0, 1, 0, 12'h001, 0);
    step(0, 1, 0, 12'hFFE, 0);
    step(0, 1, 0, 12'h400, 0);
    step(0, 0, 0, 12'h3C3, 0);
    step(0, 0, 0, 12'hABC, 1);
    step(0, 1, 0, 12'hFFE, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 12'h123, 0);
    step(0, 1, 0, 12'h123, 0);
    step(0, 0, 0, 12'h000, 0);
    step(1, 1, 1, 12'h800, 0);
    step(0, 1, 0, 12'h800, 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 19) == 0, 1'($urandom), 
           $urandom_range(0, 3) == 0, 12'($urandom), 1'($urandom));
    step(0, 0, 0, 12'h000, 0);
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 256; i++) begin
      for (int z = 0; z < 2; z++) begin
        b8.in_i   = 8'(i);
        b8.zext_i = z[0];
        #1;
        chk("n8m8", 64'(b8.out_comb_o), 64'(i));
      end
    end
    for (int i = 0; i < 2; i++) begin
      for (int z = 0; z < 2; z++) begin
        b16.in_i   = 1'(i);
        b16.zext_i = z[0];
        #1;
        chk("n16m1", 64'(b16.out_comb_o), ext_m(64'(i), 1, 16, z[0]));
      end
    end
    b16.in_i = 1'b1; b16.zext_i = 1'b0; #1;
    chk("n16m1_neg", 64'(b16.out_comb_o), 64'hFFFF);
    b16.zext_i = 1'b1; #1;
    chk("n16m1_zext", 64'(b16.out_comb_o), 64'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1, "timeout");
  end

endmodule
